// File: rtl/led_result_display.sv
// Decimal readout for the 8-bit statistics result: sequential double-dabble
// BCD conversion feeding a time-multiplexed 4-digit common-anode display.
module led_result_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       busy
);

    localparam int CW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } conv_state_t;

    conv_state_t state, next_state;

    logic [7:0]    last_value;
    logic [7:0]    shift_reg;
    logic [11:0]   bcd;
    logic [11:0]   bcd_adj;
    logic [19:0]   shifted;
    logic [2:0]    shift_cnt;
    logic [3:0]    hundreds, tens, units;

    logic [CW-1:0] refresh_cnt;
    logic [1:0]    digit_idx;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] code;
        case (d)
            4'd0:    code = 7'b1000000;
            4'd1:    code = 7'b1111001;
            4'd2:    code = 7'b0100100;
            4'd3:    code = 7'b0110000;
            4'd4:    code = 7'b0011001;
            4'd5:    code = 7'b0010010;
            4'd6:    code = 7'b0000010;
            4'd7:    code = 7'b1111000;
            4'd8:    code = 7'b0000000;
            4'd9:    code = 7'b0010000;
            default: code = 7'b1111111;
        endcase
        return code;
    endfunction

    assign dp = 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (value != last_value) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                busy       = 1'b1;
                next_state = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (shift_cnt == 3'd7) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Add-3 correction happens before the shift; a nibble never exceeds 9 here,
    // so the corrected value always fits in 4 bits.
    always_comb begin
        bcd_adj = bcd;
        for (int n = 0; n < 3; n++) begin
            if (bcd[n*4 +: 4] >= 4'd5) begin
                bcd_adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
            end
        end
        shifted = {bcd_adj, shift_reg} << 1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_value <= 8'd0;
            shift_reg  <= 8'd0;
            bcd        <= 12'd0;
            shift_cnt  <= 3'd0;
            hundreds   <= 4'd0;
            tens       <= 4'd0;
            units      <= 4'd0;
        end else begin
            case (state)
                LOAD: begin
                    shift_reg  <= value;
                    last_value <= value;
                    bcd        <= 12'd0;
                    shift_cnt  <= 3'd0;
                end
                SHIFT: begin
                    bcd       <= shifted[19:8];
                    shift_reg <= shifted[7:0];
                    shift_cnt <= shift_cnt + 3'd1;
                end
                DONE: begin
                    hundreds <= bcd[11:8];
                    tens     <= bcd[7:4];
                    units    <= bcd[3:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
        end else if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Slot 3 is always blank but still gets its anode slot to keep duty uniform.
    always_comb begin
        an_next  = ~(4'b0001 << digit_idx);
        seg_next = 7'b1111111;
        case (digit_idx)
            2'd0: seg_next = seg_decode(units);
            2'd1: begin
                if (hundreds != 4'd0 || tens != 4'd0) begin
                    seg_next = seg_decode(tens);
                end
            end
            2'd2: begin
                if (hundreds != 4'd0) begin
                    seg_next = seg_decode(hundreds);
                end
            end
            default: seg_next = 7'b1111111;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_led_result_display.sv
// Directed bench for led_result_display: scan order, blanking, conversion
// latency, back-to-back conversions and mid-conversion reset.
module tb_led_result_display;

    localparam int DIV = 4;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] BL = 7'b1111111;

    logic       clk;
    logic       rst;
    logic [7:0] value;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       busy;

    int total = 0;
    int bad   = 0;

    led_result_display #(.REFRESH_DIV(DIV)) dut (
        .clk  (clk),
        .rst  (rst),
        .value(value),
        .an   (an),
        .seg  (seg),
        .dp   (dp),
        .busy (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Wait for a conversion to start and finish; ok=0 if the bound expires.
    task automatic wait_conv(output int cycles, output bit ok);
        bit saw;
        saw    = 1'b0;
        ok     = 1'b0;
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cycles++;
            if (busy) saw = 1'b1;
            else if (saw) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Collect the segment pattern shown in each of the four anode slots.
    task automatic read_frame(output logic [6:0] d0, output logic [6:0] d1,
                              output logic [6:0] d2, output logic [6:0] d3,
                              output bit ok);
        logic [3:0] seen;
        seen = 4'b0000;
        ok   = 1'b0;
        d0 = 7'h00; d1 = 7'h00; d2 = 7'h00; d3 = 7'h00;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            case (an)
                4'b1110: begin d0 = seg; seen[0] = 1'b1; end
                4'b1101: begin d1 = seg; seen[1] = 1'b1; end
                4'b1011: begin d2 = seg; seen[2] = 1'b1; end
                4'b0111: begin d3 = seg; seen[3] = 1'b1; end
                default: ;
            endcase
            if (seen == 4'b1111) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_conversion(input logic [7:0] v,
                                  output logic [6:0] d0, output logic [6:0] d1,
                                  output logic [6:0] d2, output logic [6:0] d3,
                                  output bit conv_ok, output bit frame_ok);
        int cyc;
        value = v;
        wait_conv(cyc, conv_ok);
        repeat (2) @(negedge clk);
        read_frame(d0, d1, d2, d3, frame_ok);
    endtask

    task automatic test_reset;
        logic [3:0] onehot;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        int slot;
        rst   = 1'b1;
        value = 8'd0;
        repeat (3) @(negedge clk);
        total++; if (an !== 4'b1111) begin bad++; $display("[TB] FAIL reset_an: got %b expected 1111", an); end
        total++; if (seg !== BL) begin bad++; $display("[TB] FAIL reset_seg: got %b expected %b", seg, BL); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        total++; if (dp !== 1'b1) begin bad++; $display("[TB] FAIL reset_dp: got %b expected 1", dp); end
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            slot    = (k - 1) / 4;
            onehot  = 4'b0001 << slot;
            exp_an  = ~onehot;
            exp_seg = (slot == 0) ? S0 : BL;
            total++; if (an !== exp_an) begin bad++; $display("[TB] FAIL scan_an cycle %0d: got %b expected %b", k, an, exp_an); end
            total++; if (seg !== exp_seg) begin bad++; $display("[TB] FAIL scan_seg cycle %0d: got %b expected %b", k, seg, exp_seg); end
            total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_busy cycle %0d: got %b expected 0", k, busy); end
        end
    endtask

    task automatic test_255;
        int busy_cnt;
        logic [6:0] d0, d1, d2, d3;
        bit ok;
        busy_cnt = 0;
        value = 8'd255;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        total++; if (busy_cnt != 9) begin bad++; $display("[TB] FAIL busy_len_255: got %0d expected 9", busy_cnt); end
        read_frame(d0, d1, d2, d3, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL frame_255: got incomplete scan expected all four slots"); end
        total++; if (d2 !== S2) begin bad++; $display("[TB] FAIL d2_255: got %b expected %b", d2, S2); end
        total++; if (d1 !== S5) begin bad++; $display("[TB] FAIL d1_255: got %b expected %b", d1, S5); end
        total++; if (d0 !== S5) begin bad++; $display("[TB] FAIL d0_255: got %b expected %b", d0, S5); end
        total++; if (d3 !== BL) begin bad++; $display("[TB] FAIL d3_255: got %b expected %b", d3, BL); end
    endtask

    task automatic test_blank_7;
        logic [6:0] d0, d1, d2, d3;
        bit cok, fok;
        run_conversion(8'd7, d0, d1, d2, d3, cok, fok);
        total++; if (!(cok && fok)) begin bad++; $display("[TB] FAIL timeout_7: got conv=%0d frame=%0d expected 1 1", cok, fok); end
        total++; if (d0 !== S7) begin bad++; $display("[TB] FAIL d0_7: got %b expected %b", d0, S7); end
        total++; if (d1 !== BL) begin bad++; $display("[TB] FAIL d1_7: got %b expected %b", d1, BL); end
        total++; if (d2 !== BL) begin bad++; $display("[TB] FAIL d2_7: got %b expected %b", d2, BL); end
    endtask

    task automatic test_middle_zero;
        logic [6:0] d0, d1, d2, d3;
        bit cok, fok;
        run_conversion(8'd105, d0, d1, d2, d3, cok, fok);
        total++; if (!(cok && fok)) begin bad++; $display("[TB] FAIL timeout_105: got conv=%0d frame=%0d expected 1 1", cok, fok); end
        total++; if (d2 !== S1) begin bad++; $display("[TB] FAIL d2_105: got %b expected %b", d2, S1); end
        total++; if (d1 !== S0) begin bad++; $display("[TB] FAIL d1_105: got %b expected %b", d1, S0); end
        total++; if (d0 !== S5) begin bad++; $display("[TB] FAIL d0_105: got %b expected %b", d0, S5); end
    endtask

    task automatic test_back_to_back;
        int c;
        bit fell;
        logic [6:0] exp_seg, d0, d1, d2, d3;
        bit ok;
        value = 8'd40;
        repeat (3) @(negedge clk);
        value = 8'd200;
        c = 3;
        fell = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            c++;
            if (!busy) begin fell = 1'b1; break; end
        end
        total++; if (!fell) begin bad++; $display("[TB] FAIL b2b_first_done: got busy stuck expected fall"); end
        repeat (2) @(negedge clk);
        c += 2;
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_restart: got busy=%b expected 1", busy); end
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin @(negedge clk); c++; end
            case (an)
                4'b1110: exp_seg = S0;
                4'b1101: exp_seg = S4;
                default: exp_seg = BL;
            endcase
            total++; if (seg !== exp_seg) begin bad++; $display("[TB] FAIL b2b_show40 an=%b: got %b expected %b", an, seg, exp_seg); end
        end
        fell = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            c++;
            if (!busy) begin fell = 1'b1; break; end
        end
        total++; if (!fell || c > 22) begin bad++; $display("[TB] FAIL b2b_latency: got %0d cycles expected <= 22", c); end
        @(negedge clk);
        read_frame(d0, d1, d2, d3, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL frame_200: got incomplete scan expected all four slots"); end
        total++; if (d2 !== S2) begin bad++; $display("[TB] FAIL d2_200: got %b expected %b", d2, S2); end
        total++; if (d1 !== S0) begin bad++; $display("[TB] FAIL d1_200: got %b expected %b", d1, S0); end
        total++; if (d0 !== S0) begin bad++; $display("[TB] FAIL d0_200: got %b expected %b", d0, S0); end
    endtask

    task automatic test_reset_mid;
        bit started, cok, ok;
        int cyc;
        logic [6:0] d0, d1, d2, d3;
        value = 8'd123;
        started = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy) begin started = 1'b1; break; end
        end
        total++; if (!started) begin bad++; $display("[TB] FAIL rmid_start: got busy=0 expected 1"); end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (an !== 4'b1111) begin bad++; $display("[TB] FAIL rmid_an: got %b expected 1111", an); end
        total++; if (seg !== BL) begin bad++; $display("[TB] FAIL rmid_seg: got %b expected %b", seg, BL); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rmid_busy: got %b expected 0", busy); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (an !== 4'b1110) begin bad++; $display("[TB] FAIL rmid_first_an: got %b expected 1110", an); end
        total++; if (seg !== S0) begin bad++; $display("[TB] FAIL rmid_first_seg: got %b expected %b", seg, S0); end
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL rmid_reconvert: got %b expected 1", busy); end
        wait_conv(cyc, cok);
        total++; if (!cok) begin bad++; $display("[TB] FAIL rmid_done: got timeout after %0d cycles expected finish", cyc); end
        repeat (2) @(negedge clk);
        read_frame(d0, d1, d2, d3, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL frame_123: got incomplete scan expected all four slots"); end
        total++; if (d2 !== S1) begin bad++; $display("[TB] FAIL d2_123: got %b expected %b", d2, S1); end
        total++; if (d1 !== S2) begin bad++; $display("[TB] FAIL d1_123: got %b expected %b", d1, S2); end
        total++; if (d0 !== S3) begin bad++; $display("[TB] FAIL d0_123: got %b expected %b", d0, S3); end
    endtask

    initial begin
        rst   = 1'b1;
        value = 8'd0;
        $display("[TB] starting led_result_display bench");
        test_reset();
        test_255();
        test_blank_7();
        test_middle_zero();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
